schmidl_cox_preamble_inserter: RTL and testbench

- Transmit-side counterpart of the Schmidl-Cox detector.
- Takes a continuous stream of sc16 payload samples and builds bursts. Each burst is a two-half repeated preamble, then `cfg_frame_len` payload samples, then `cfg_gap_len` zero samples, so the receiver's autocorrelation metric has a plateau to detect.
- Sits in the `ce_clk` domain between the OFDM modulator output and the block's output AXI-Stream port. It is driven by the block's register interface.

---
 rtl/schmidl_cox_tx_pkg.sv | 23 ++
 rtl/sc_preamble_ram.sv | 31 +++
 rtl/schmidl_cox_preamble_inserter.sv | 229 ++++++++++++++++++++++
 tb/tb_schmidl_cox_preamble_inserter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/schmidl_cox_tx_pkg.sv
// Shared types for the Schmidl-Cox transmit-side preamble inserter.
package schmidl_cox_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRE_A   = 3'd1,
    ST_PRE_B   = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_GAP     = 3'd4
  } sc_tx_state_t;

  // Packed complex sample: I in the upper half, Q in the lower half.
  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } sc16_t;

  localparam sc16_t SC16_ZERO = '{i: 16'sd0, q: 16'sd0};

  // Width of the per-burst length registers and the index counter.
  localparam int LEN_W = 16;

endpackage

// File: rtl/sc_preamble_ram.sv
// Small distributed RAM holding one preamble half. Synchronous write,
// asynchronous read so the FSM can emit a preamble sample every cycle.
module sc_preamble_ram #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             addr_ok;

  // Addresses past the preamble length are silently dropped.
  assign addr_ok = (32'(wr_addr) < 32'(DEPTH));

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en && addr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/schmidl_cox_preamble_inserter.sv
// Builds transmit bursts: two identical preamble halves, frame_len payload
// samples taken from the input stream, then gap_len zero samples.
//
// Handshake semantics (both AXI-Stream ports): a transfer happens on a rising
// edge where tvalid && tready. Once m_axis_tvalid is high, m_axis_tdata and
// m_axis_tlast hold until the transfer. s_axis_tready depends only on state
// and the output register, never on s_axis_tvalid.
module schmidl_cox_preamble_inserter
  import schmidl_cox_tx_pkg::*;
#(
  parameter int ITEM_W   = 32,
  parameter int HALF_LEN = 64,
  parameter int ADDR_W   = $clog2(HALF_LEN)
) (
  input  logic              ce_clk,
  input  logic              ce_rst,
  input  logic              cfg_enable,
  input  logic [15:0]       cfg_frame_len,
  input  logic [15:0]       cfg_gap_len,
  input  logic              cfg_pre_wr_en,
  input  logic [ADDR_W-1:0] cfg_pre_wr_addr,
  input  logic [ITEM_W-1:0] cfg_pre_wr_data,
  input  logic [ITEM_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [ITEM_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic [31:0]       frame_count,
  output logic              err_len
);

  localparam logic [LEN_W-1:0]  HALF_LAST = LEN_W'(HALF_LEN - 1);
  localparam logic [ITEM_W-1:0] ZERO_ITEM = ITEM_W'(SC16_ZERO);

  sc_tx_state_t      state, state_n;
  logic [LEN_W-1:0]  idx, idx_n;
  logic [LEN_W-1:0]  frame_len_q, gap_len_q;
  logic [LEN_W-1:0]  frame_last, gap_last;
  // tail: the final burst sample sits in the output register and the FSM
  // waits for its handshake before returning to IDLE.
  logic              tail, tail_n;
  logic              load;
  logic              latch_cfg;
  logic              emit;
  logic [ITEM_W-1:0] emit_data;
  logic              emit_last;
  logic              err_set;
  logic              burst_done;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [ITEM_W-1:0] ram_rd_data;

  // Output register may take a new sample when empty or being drained.
  assign load        = !m_axis_tvalid || m_axis_tready;
  assign busy        = (state != ST_IDLE);
  assign frame_last  = frame_len_q - 16'd1;
  assign gap_last    = gap_len_q - 16'd1;
  assign ram_wr_en   = cfg_pre_wr_en && (state == ST_IDLE);
  assign ram_rd_addr = idx[ADDR_W-1:0];

  sc_preamble_ram #(
    .DEPTH  (HALF_LEN),
    .WIDTH  (ITEM_W),
    .ADDR_W (ADDR_W)
  ) u_pre_ram (
    .clk     (ce_clk),
    .wr_en   (ram_wr_en),
    .wr_addr (cfg_pre_wr_addr),
    .wr_data (cfg_pre_wr_data),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  // State, index and tail registers.
  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      tail  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      tail  <= tail_n;
    end
  end

  // Burst lengths are captured at burst start so mid-burst config edits
  // only affect the next burst.
  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      frame_len_q <= '0;
      gap_len_q   <= '0;
    end else if (latch_cfg) begin
      frame_len_q <= cfg_frame_len;
      gap_len_q   <= cfg_gap_len;
    end
  end

  // Next-state logic: sequences the burst and selects the sample to emit.
  always_comb begin
    state_n       = state;
    idx_n         = idx;
    tail_n        = tail;
    latch_cfg     = 1'b0;
    emit          = 1'b0;
    emit_data     = ram_rd_data;
    emit_last     = 1'b0;
    s_axis_tready = 1'b0;
    err_set       = 1'b0;
    burst_done    = 1'b0;
    if (tail) begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        state_n    = ST_IDLE;
        tail_n     = 1'b0;
        burst_done = 1'b1;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_enable && s_axis_tvalid) begin
            latch_cfg = 1'b1;
            idx_n     = '0;
            state_n   = ST_PRE_A;
          end
        end
        ST_PRE_A: begin
          if (load) begin
            emit = 1'b1;
            if (idx == HALF_LAST) begin
              idx_n   = '0;
              state_n = ST_PRE_B;
            end else begin
              idx_n = idx + 16'd1;
            end
          end
        end
        ST_PRE_B: begin
          if (load) begin
            emit = 1'b1;
            if (idx == HALF_LAST) begin
              idx_n = '0;
              if (frame_len_q != '0) begin
                state_n = ST_PAYLOAD;
              end else if (gap_len_q != '0) begin
                state_n = ST_GAP;
              end else begin
                emit_last = 1'b1;
                tail_n    = 1'b1;
              end
            end else begin
              idx_n = idx + 16'd1;
            end
          end
        end
        ST_PAYLOAD: begin
          s_axis_tready = load;
          if (load && s_axis_tvalid) begin
            emit      = 1'b1;
            emit_data = s_axis_tdata;
            if (idx == frame_last) begin
              err_set = !s_axis_tlast;
              idx_n   = '0;
              if (gap_len_q != '0) begin
                state_n = ST_GAP;
              end else begin
                emit_last = 1'b1;
                tail_n    = 1'b1;
              end
            end else begin
              err_set = s_axis_tlast;
              idx_n   = idx + 16'd1;
            end
          end
        end
        ST_GAP: begin
          if (load) begin
            emit      = 1'b1;
            emit_data = ZERO_ITEM;
            if (idx == gap_last) begin
              emit_last = 1'b1;
              tail_n    = 1'b1;
            end else begin
              idx_n = idx + 16'd1;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          idx_n   = '0;
        end
      endcase
    end
  end

  // Single output register stage; holds data while stalled.
  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (load) begin
      m_axis_tvalid <= emit;
      m_axis_tlast  <= emit && emit_last;
      if (emit) begin
        m_axis_tdata <= emit_data;
      end
    end
  end

  // Completed-burst counter and sticky input-tlast alignment flag.
  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      frame_count <= '0;
      err_len     <= 1'b0;
    end else begin
      if (burst_done) begin
        frame_count <= frame_count + 32'd1;
      end
      if (err_set) begin
        err_len <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_schmidl_cox_preamble_inserter.sv
// Directed bench for the preamble inserter with a scoreboard of expected
// output samples ({tlast, tdata}) and a payload source queue.
module tb_schmidl_cox_preamble_inserter;

  localparam int HALF = 4;
  localparam int AW   = 2;

  // ---------------- clock / reset ----------------
  logic ce_clk = 1'b0;
  logic ce_rst = 1'b1;
  initial forever #5 ce_clk = ~ce_clk;

  // ---------------- DUT signals ----------------
  logic          cfg_enable = 1'b1;
  logic [15:0]   cfg_frame_len = '0;
  logic [15:0]   cfg_gap_len = '0;
  logic          cfg_pre_wr_en = 1'b0;
  logic [AW-1:0] cfg_pre_wr_addr = '0;
  logic [31:0]   cfg_pre_wr_data = '0;
  logic [31:0]   s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          busy;
  logic [31:0]   frame_count;
  logic          err_len;

  logic          src_v = 1'b0;
  logic          force_v = 1'b0;
  logic [31:0]   src_d = '0;
  logic          src_l = 1'b0;
  assign s_axis_tvalid = src_v | force_v;
  assign s_axis_tdata  = src_d;
  assign s_axis_tlast  = src_l;

  schmidl_cox_preamble_inserter #(
    .ITEM_W   (32),
    .HALF_LEN (HALF),
    .ADDR_W   (AW)
  ) dut (
    .ce_clk          (ce_clk),
    .ce_rst          (ce_rst),
    .cfg_enable      (cfg_enable),
    .cfg_frame_len   (cfg_frame_len),
    .cfg_gap_len     (cfg_gap_len),
    .cfg_pre_wr_en   (cfg_pre_wr_en),
    .cfg_pre_wr_addr (cfg_pre_wr_addr),
    .cfg_pre_wr_data (cfg_pre_wr_data),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .busy            (busy),
    .frame_count     (frame_count),
    .err_len         (err_len)
  );

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q[$];
  logic [32:0] src_q[$];
  logic [31:0] pre_m [HALF];
  int          n_tests = 0;
  int          n_fail = 0;
  int          stall_pct = 0;
  bit          mon_en = 1'b0;
  bit          saw_sready = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic ram_write(input int a, input logic [31:0] d, input bit accepted);
    @(posedge ce_clk); #1;
    cfg_pre_wr_en   = 1'b1;
    cfg_pre_wr_addr = AW'(a);
    cfg_pre_wr_data = d;
    @(posedge ce_clk); #1;
    cfg_pre_wr_en = 1'b0;
    if (accepted) pre_m[a] = d;
  endtask

  // Sets config, queues payload input and the expected burst output.
  task automatic push_burst(input int fl, input int gl, input logic [31:0] base, input bit bad_last);
    cfg_frame_len = 16'(fl);
    cfg_gap_len   = 16'(gl);
    for (int h = 0; h < 2; h++)
      for (int i = 0; i < HALF; i++)
        exp_q.push_back({1'(fl == 0 && gl == 0 && h == 1 && i == HALF - 1), pre_m[i]});
    for (int i = 0; i < fl; i++) begin
      exp_q.push_back({1'(gl == 0 && i == fl - 1), base + 32'(i)});
      src_q.push_back({bad_last ? 1'(i == 1) : 1'(i == fl - 1), base + 32'(i)});
    end
    for (int i = 0; i < gl; i++) exp_q.push_back({1'(i == gl - 1), 32'h0});
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 100) begin @(negedge ce_clk); n++; end
    chk("busy_rise", 64'(busy), 64'(1));
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (frame_count != 32'(target) && n < 2000) begin @(negedge ce_clk); n++; end
    chk("frame_count", 64'(frame_count), 64'(target));
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
  endtask

  // Payload source: presents the queue head, advances on handshake.
  initial begin
    bit hs;
    forever begin
      @(negedge ce_clk);
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge ce_clk); #1;
      if (hs && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        src_v = 1'b1;
        {src_l, src_d} = src_q[0];
      end else begin
        src_v = 1'b0;
      end
    end
  end

  // Output back-pressure generator.
  initial forever begin
    @(posedge ce_clk); #1;
    m_axis_tready = ($urandom_range(0, 99) >= stall_pct);
  end

  // Output monitor: stall stability and in-order scoreboard compare.
  logic [32:0] prev_o = '0;
  bit          prev_stall = 1'b0;
  always @(negedge ce_clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        chk("stall_valid", 64'(m_axis_tvalid), 64'(1));
        chk("stall_hold", 64'({m_axis_tlast, m_axis_tdata}), 64'(prev_o));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $error("FAIL out_extra: got %0h expected none", {m_axis_tlast, m_axis_tdata});
        end else begin
          chk("out_sample", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_q.pop_front()));
        end
      end
      if (s_axis_tready) saw_sready = 1'b1;
    end
    prev_stall = mon_en && m_axis_tvalid && !m_axis_tready;
    prev_o     = {m_axis_tlast, m_axis_tdata};
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    repeat (3) @(posedge ce_clk);
    @(negedge ce_clk);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_m_tlast", 64'(m_axis_tlast), 64'(0));
    chk("rst_m_tdata", 64'(m_axis_tdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_frame_count", 64'(frame_count), 64'(0));
    chk("rst_err_len", 64'(err_len), 64'(0));
    chk("rst_s_tready", 64'(s_axis_tready), 64'(0));
    @(posedge ce_clk); #1;
    ce_rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < HALF; i++) ram_write(i, 32'(i + 1), 1'b1);

    // Basic burst, no back-pressure, with start-latency check.
    stall_pct = 0;
    @(negedge ce_clk);
    push_burst(3, 2, 32'hA000_0000, 1'b0);
    wait_busy();
    chk("lat_pre_a_tvalid", 64'(m_axis_tvalid), 64'(0));
    @(negedge ce_clk);
    chk("lat_first_tvalid", 64'(m_axis_tvalid), 64'(1));
    chk("lat_first_tdata", 64'(m_axis_tdata), 64'(pre_m[0]));
    wait_done(1);
    chk("basic_err_len", 64'(err_len), 64'(0));

    // Same burst under 25% output stall.
    stall_pct = 25;
    push_burst(3, 2, 32'hB000_0000, 1'b0);
    wait_done(2);

    // Zero payload and zero gap: preamble only, input never accepted.
    saw_sready = 1'b0;
    push_burst(0, 0, 32'h0, 1'b0);
    force_v = 1'b1;
    wait_done(3);
    force_v = 1'b0;
    chk("zero_len_no_sready", 64'(saw_sready), 64'(0));

    // Input tlast on the wrong sample sets the sticky error.
    push_burst(3, 2, 32'hC000_0000, 1'b1);
    wait_done(4);
    chk("err_len_set", 64'(err_len), 64'(1));
    push_burst(3, 2, 32'hC100_0000, 1'b0);
    wait_done(5);
    chk("err_len_sticky", 64'(err_len), 64'(1));

    // Frame length changed mid-burst; next burst queued back-to-back.
    push_burst(3, 2, 32'hD000_0000, 1'b0);
    wait_busy();
    push_burst(5, 1, 32'hD100_0000, 1'b0);
    wait_done(7);

    // Preamble RAM write while busy is dropped, in IDLE it lands.
    push_burst(2, 1, 32'hE000_0000, 1'b0);
    wait_busy();
    ram_write(0, 32'h7FFF_0000, 1'b0);
    wait_done(8);
    push_burst(2, 1, 32'hE100_0000, 1'b0);
    wait_done(9);
    ram_write(0, 32'h7FFF_0000, 1'b1);
    push_burst(2, 1, 32'hE200_0000, 1'b0);
    wait_done(10);

    // Reset during payload.
    push_burst(3, 2, 32'hF000_0000, 1'b0);
    n = 0;
    while (!s_axis_tready && n < 200) begin @(negedge ce_clk); n++; end
    chk("reach_payload", 64'(s_axis_tready), 64'(1));
    @(posedge ce_clk); #1;
    ce_rst = 1'b1;
    mon_en = 1'b0;
    @(negedge ce_clk);
    src_q.delete();
    @(posedge ce_clk); #1;
    ce_rst = 1'b0;
    @(negedge ce_clk);
    chk("midrst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_frame_count", 64'(frame_count), 64'(0));
    chk("midrst_err_len", 64'(err_len), 64'(0));
    exp_q.delete();
    mon_en = 1'b1;
    push_burst(3, 2, 32'hF100_0000, 1'b0);
    wait_done(1);
    chk("post_rst_err_len", 64'(err_len), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
